dds_phase2amp: RTL and testbench

Phase-to-amplitude converter directly downstream of the DDS phase accumulator. Takes the 32-bit accumulated phase word and an 11-bit phase offset, and forms an 11-bit table index. Produces one 10-bit unsigned (offset-binary) sample per valid phase: sine, square, triangle or sawtooth. Output feeds the DAC interface stage.

---
 rtl/dds_pkg.sv | 46 ++++
 rtl/dds_sine_rom.sv | 26 ++
 rtl/dds_phase2amp.sv | 101 ++++++++++
 tb/tb_dds_phase2amp.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared definitions for the DDS phase-to-amplitude path: widths, waveform
// encodings and the elaboration-time quarter-wave sine table generator.
package dds_pkg;

    localparam int PHASE_W   = 32;
    localparam int IDX_W     = 11;
    localparam int AMP_W     = 10;
    localparam int ROM_AW    = IDX_W - 2;
    localparam int ROM_DW    = AMP_W - 1;
    localparam int ROM_DEPTH = 1 << ROM_AW;

    localparam logic [AMP_W-1:0] AMP_MID = AMP_W'(1 << (AMP_W - 1));
    localparam logic [AMP_W-1:0] AMP_MAX = '1;

    typedef enum logic [1:0] {
        WAVE_SINE   = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_SAW    = 2'd3
    } wave_e;

    // pi in Q30 fixed point; table peak is 2^(AMP_W-1) - 1
    localparam longint PI_Q30   = 64'sd3373259426;
    localparam longint ROM_PEAK = 64'sd511;

    // round(511 * sin(2*pi*(a+0.5)/2048)) via a Q30 Taylor series, so the
    // table is built at elaboration with integer arithmetic only.
    function automatic logic [ROM_DW-1:0] quarter_sine(input int unsigned a);
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint scaled;
        x    = (PI_Q30 * longint'(2 * a + 1) + 64'sd1024) >>> 11;
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int k = 1; k <= 8; k++) begin
            term = -(((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1)));
            sum  = sum + term;
        end
        scaled = (ROM_PEAK * sum + (64'sd1 <<< 29)) >>> 30;
        return ROM_DW'(scaled);
    endfunction

endpackage

// File: rtl/dds_sine_rom.sv
// 512x9 synchronous quarter-wave sine ROM; contents generated at elaboration.
module dds_sine_rom
    import dds_pkg::*;
(
    input  logic              clk,
    input  logic [ROM_AW-1:0] addr,
    output logic [ROM_DW-1:0] data
);

    logic [ROM_DW-1:0] w_table [ROM_DEPTH];
    logic [ROM_DW-1:0] r_data;

    for (genvar g = 0; g < ROM_DEPTH; g++) begin : g_entry
        localparam logic [ROM_DW-1:0] ENTRY = quarter_sine(g);
        assign w_table[g] = ENTRY;
    end

    // NOTE: the ROM read register has no reset so it maps onto block memory;
    // its contents are qualified by the valid pipeline alongside it.
    always_ff @(posedge clk) begin
        r_data <= w_table[addr];
    end

    assign data = r_data;

endmodule

// File: rtl/dds_phase2amp.sv
// Three-stage phase-to-amplitude converter: index/offset, ROM lookup, waveform mux.
module dds_phase2amp
    import dds_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PHASE_W-1:0] phase_in,
    input  logic               phase_vld,
    input  logic [IDX_W-1:0]   p_off,
    input  logic [1:0]         wave_sel,
    output logic [AMP_W-1:0]   amp,
    output logic               amp_vld
);

    localparam int LSB_W = PHASE_W - IDX_W;

    logic [IDX_W-1:0]  r_s1_idx;
    wave_e             r_s1_wave;
    logic              r_s1_vld;

    logic [IDX_W-1:0]  r_s2_idx;
    wave_e             r_s2_wave;
    logic              r_s2_vld;

    logic [ROM_AW-1:0] w_rom_addr;
    logic [ROM_DW-1:0] w_rom_data;
    logic [AMP_W-1:0]  w_amp_next;

    logic [AMP_W-1:0]  r_amp;
    logic              r_amp_vld;

    // Phase LSBs are truncated away without dither.
    logic w_unused_lsbs;
    assign w_unused_lsbs = ^phase_in[LSB_W-1:0];

    // NOTE: registered state uses non-blocking assignments so every stage
    // samples the previous stage's value from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_idx  <= '0;
            r_s1_wave <= WAVE_SINE;
            r_s1_vld  <= 1'b0;
        end else begin
            r_s1_idx  <= phase_in[PHASE_W-1 -: IDX_W] + p_off;
            r_s1_wave <= wave_e'(wave_sel);
            r_s1_vld  <= phase_vld;
        end
    end

    // Odd quadrants read the quarter wave backwards.
    assign w_rom_addr = r_s1_idx[ROM_AW] ? ~r_s1_idx[ROM_AW-1:0] : r_s1_idx[ROM_AW-1:0];

    dds_sine_rom u_rom (
        .clk  (clk),
        .addr (w_rom_addr),
        .data (w_rom_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_idx  <= '0;
            r_s2_wave <= WAVE_SINE;
            r_s2_vld  <= 1'b0;
        end else begin
            r_s2_idx  <= r_s1_idx;
            r_s2_wave <= r_s1_wave;
            r_s2_vld  <= r_s1_vld;
        end
    end

    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        w_amp_next = AMP_MID;
        unique case (r_s2_wave)
            WAVE_SINE:   w_amp_next = r_s2_idx[IDX_W-1]
                                      ? AMP_MID - AMP_W'(1) - {1'b0, w_rom_data}
                                      : AMP_MID + {1'b0, w_rom_data};
            WAVE_SQUARE: w_amp_next = r_s2_idx[IDX_W-1] ? '0 : AMP_MAX;
            WAVE_TRI:    w_amp_next = r_s2_idx[IDX_W-1] ? ~r_s2_idx[AMP_W-1:0]
                                                        : r_s2_idx[AMP_W-1:0];
            WAVE_SAW:    w_amp_next = r_s2_idx[IDX_W-1:1];
        endcase
    end

    // Bubbles leave amp untouched so the DAC never sees a midscale glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_amp     <= AMP_MID;
            r_amp_vld <= 1'b0;
        end else begin
            r_amp_vld <= r_s2_vld;
            if (r_s2_vld) begin
                r_amp <= w_amp_next;
            end
        end
    end

    assign amp     = r_amp;
    assign amp_vld = r_amp_vld;

endmodule

// File: tb/tb_dds_phase2amp.sv
// Self-checking bench: behavioural model from real-valued sine, directed and random stimulus.
module tb_dds_phase2amp;

    localparam real PI = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] phase_in  = '0;
    logic        phase_vld = 1'b0;
    logic [10:0] p_off     = '0;
    logic [1:0]  wave_sel  = '0;
    logic [9:0]  amp;
    logic        amp_vld;

    int checks = 0;
    int errors = 0;

    dds_phase2amp dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .phase_in  (phase_in),
        .phase_vld (phase_vld),
        .p_off     (p_off),
        .wave_sel  (wave_sel),
        .amp       (amp),
        .amp_vld   (amp_vld)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected amplitude straight from the waveform definitions.
    function automatic int ref_amp(input logic [31:0] ph, input logic [10:0] off,
                                   input logic [1:0] w);
        int  idx;
        int  m;
        int  res;
        real s;
        idx = (int'(ph[31:21]) + int'(off)) % 2048;
        case (w)
            2'd0: begin
                s   = $sin(2.0 * PI * (real'(idx) + 0.5) / 2048.0);
                m   = $rtoi(511.0 * ((s < 0.0) ? -s : s) + 0.5);
                res = (s > 0.0) ? 512 + m : 511 - m;
            end
            2'd1:    res = (idx >= 1024) ? 0 : 1023;
            2'd2:    res = (idx >= 1024) ? 2047 - idx : idx;
            default: res = idx / 2;
        endcase
        return res;
    endfunction

    typedef struct {
        bit vld;
        int amp;
    } smp_t;

    smp_t pipe_q[$];
    int   exp_amp = 512;
    bit   exp_vld = 1'b0;

    // Model: output after edge k reflects the sample taken at edge k-2.
    initial begin
        smp_t s;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                pipe_q.delete();
                exp_amp = 512;
                exp_vld = 1'b0;
            end else begin
                s.vld = phase_vld;
                s.amp = phase_vld ? ref_amp(phase_in, p_off, wave_sel) : 0;
                pipe_q.push_back(s);
                if (pipe_q.size() >= 3) begin
                    s       = pipe_q.pop_front();
                    exp_vld = s.vld;
                    if (s.vld) exp_amp = s.amp;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("cmp_amp_vld", int'(amp_vld), int'(exp_vld));
            check("cmp_amp", int'(amp), exp_amp);
        end
    end

    bit sweep_en = 1'b0;
    int sweep_q[$];

    initial begin
        forever begin
            @(negedge clk);
            if (sweep_en && amp_vld) sweep_q.push_back(int'(amp));
        end
    end

    task automatic drain(input int n);
        phase_vld = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic one_shot(input string name, input logic [31:0] ph, input logic [10:0] off,
                            input logic [1:0] w, input int exp);
        phase_in = ph; p_off = off; wave_sel = w; phase_vld = 1'b1;
        @(posedge clk); #1;
        phase_vld = 1'b0;
        phase_in  = $urandom;
        p_off     = 11'($urandom);
        wave_sel  = 2'($urandom);
        repeat (2) @(posedge clk);
        #1;
        check({name, "_vld"}, int'(amp_vld), 1);
        check(name, int'(amp), exp);
        @(posedge clk); #1;
        check({name, "_hold"}, int'(amp), exp);
    endtask

    int pat_vld [4] = '{1, 0, 1, 1};
    int pat_w   [4] = '{0, 0, 3, 0};
    int pat_ph  [4] = '{32'h0000_0000, 32'h1234_5678, 32'hC000_0000, 32'h4000_0000};
    int lit_vld [4] = '{1, 0, 1, 1};
    int lit_amp [4] = '{513, 513, 768, 1023};

    initial begin
        int d;
        int max_step;
        int mono_bad;
        int mn;
        int mx;

        // Pin the model against hand-derived values.
        check("model_sine_q0", ref_amp(32'h0000_0000, 11'd0, 2'd0), 513);
        check("model_sine_q1", ref_amp(32'h4000_0000, 11'd0, 2'd0), 1023);
        check("model_tri_1536", ref_amp(32'hC000_0000, 11'd0, 2'd2), 511);

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_amp", int'(amp), 512);
        check("reset_vld", int'(amp_vld), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        one_shot("sine_0",      32'h0000_0000, 11'd0,    2'd0, 513);
        one_shot("sine_4000",   32'h4000_0000, 11'd0,    2'd0, 1023);
        one_shot("sine_8000",   32'h8000_0000, 11'd0,    2'd0, 510);
        one_shot("off_1024",    32'h0000_0000, 11'd1024, 2'd0, 510);
        one_shot("wrap_ffe0",   32'hFFE0_0000, 11'd1,    2'd0, 513);
        one_shot("square_c000", 32'hC000_0000, 11'd0,    2'd1, 0);
        one_shot("tri_c000",    32'hC000_0000, 11'd0,    2'd2, 511);
        one_shot("saw_c000",    32'hC000_0000, 11'd0,    2'd3, 768);
        one_shot("square_2000", 32'h2000_0000, 11'd0,    2'd1, 1023);
        drain(4);

        // Bubble pattern with per-sample waveform switching.
        p_off = '0;
        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin
                phase_vld = pat_vld[c][0];
                wave_sel  = 2'(pat_w[c]);
                phase_in  = pat_ph[c];
            end else begin
                phase_vld = 1'b0;
            end
            @(posedge clk); #1;
            if (c >= 2) begin
                check($sformatf("bubble_vld_%0d", c - 2), int'(amp_vld), lit_vld[c - 2]);
                check($sformatf("bubble_amp_%0d", c - 2), int'(amp), lit_amp[c - 2]);
            end
        end
        drain(4);

        // Full sine sweep, one index per cycle.
        sweep_en = 1'b1;
        for (int i = 0; i < 2048; i++) begin
            phase_in = 32'(i) << 21; p_off = '0; wave_sel = 2'd0; phase_vld = 1'b1;
            @(posedge clk); #1;
        end
        drain(5);
        sweep_en = 1'b0;
        check("sweep_count", sweep_q.size(), 2048);
        if (sweep_q.size() == 2048) begin
            max_step = 0; mono_bad = 0; mn = 1023; mx = 0;
            for (int i = 0; i < 2048; i++) begin
                if (sweep_q[i] < mn) mn = sweep_q[i];
                if (sweep_q[i] > mx) mx = sweep_q[i];
                if (i > 0) begin
                    d = sweep_q[i] - sweep_q[i - 1];
                    if ((d < 0 ? -d : d) > max_step) max_step = (d < 0 ? -d : d);
                    if ((i % 512) != 0) begin
                        if ((i < 512 || i >= 1536) && d < 0) mono_bad++;
                        if (i >= 512 && i < 1536 && d > 0) mono_bad++;
                    end
                end
            end
            check("sweep_monotonic_violations", mono_bad, 0);
            check("sweep_max_step_le3", int'(max_step <= 3), 1);
            check("sweep_min", mn, 0);
            check("sweep_max", mx, 1023);
            check("sweep_idx512", sweep_q[512], 1023);
            check("sweep_idx1024", sweep_q[1024], 510);
        end

        // Asynchronous reset in the middle of a valid stream.
        for (int i = 0; i < 5; i++) begin
            phase_in = $urandom; p_off = 11'($urandom); wave_sel = 2'($urandom);
            phase_vld = 1'b1;
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_amp", int'(amp), 512);
        check("async_rst_vld", int'(amp_vld), 0);
        @(negedge clk);
        phase_vld = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("no_stale_vld_%0d", i), int'(amp_vld), 0);
        end

        // Random traffic with one reset in the middle.
        for (int i = 0; i < 1500; i++) begin
            phase_in  = $urandom;
            p_off     = 11'($urandom_range(0, 2047));
            wave_sel  = 2'($urandom_range(0, 3));
            phase_vld = ($urandom_range(0, 3) != 0);
            if (i == 700) begin
                #3 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            @(posedge clk); #1;
        end
        drain(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
